// File: rtl/date_setter_pkg.sv
// Shared field widths, encodings and reset date for the date entry controller.
// Packed date word order (shared with the keeper): {day, month, year}, day in the MSBs.
package date_setter_pkg;

  localparam int unsigned DAY_W = 5;
  localparam int unsigned MON_W = 4;

  typedef enum logic [1:0] {
    FLD_DAY  = 2'd0,
    FLD_MON  = 2'd1,
    FLD_YEAR = 2'd2
  } field_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EDIT,
    ST_COMMIT
  } state_t;

  localparam logic [DAY_W-1:0] RST_DAY  = 5'd1;
  localparam logic [MON_W-1:0] RST_MON  = 4'd1;
  localparam logic [DAY_W+MON_W-1:0] RST_DAY_MON = {RST_DAY, RST_MON};

endpackage

// File: rtl/date_month_len.sv
// Number of days in a month; leap years use only the divisible-by-4 rule.
module date_month_len
  import date_setter_pkg::*;
(
  input  logic [MON_W-1:0] month,
  input  logic [1:0]       year_lo,
  output logic [DAY_W-1:0] day_max
);

  always_comb begin
    day_max = 5'd31;
    case (month)
      4'd4, 4'd6, 4'd9, 4'd11: day_max = 5'd30;
      4'd2:                    day_max = (year_lo == 2'b00) ? 5'd29 : 5'd28;
      default:                 ;
    endcase
  end

endmodule

// File: rtl/date_setter.sv
// Date entry controller: captures the current date, edits day/month/year with
// step buttons and commits a packed date with a single-cycle overwrite pulse.
module date_setter
  import date_setter_pkg::*;
#(
  parameter int unsigned YEAR_W = 12
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DAY_W+MON_W+YEAR_W-1:0] date_cur,
  input  logic                          edit_btn,
  input  logic                          next_btn,
  input  logic                          up_btn,
  input  logic                          down_btn,
  output logic [DAY_W+MON_W+YEAR_W-1:0] date_in,
  output logic                          date_ow,
  output logic                          editing,
  output logic [1:0]                    field_sel
);

  localparam int unsigned DATE_W = DAY_W + MON_W + YEAR_W;

  state_t state, state_nx;
  field_t fld, fld_nx;

  logic [DAY_W-1:0]  day, day_nx, cap_day, mon_max;
  logic [MON_W-1:0]  mon, mon_nx, cap_mon;
  logic [YEAR_W-1:0] year, year_nx;
  logic [DATE_W-1:0] date_nx;
  logic              ow_nx;
  logic              step_up, step_dn, capture, field_step;

  assign cap_day    = date_cur[YEAR_W+MON_W +: DAY_W];
  assign cap_mon    = date_cur[YEAR_W +: MON_W];
  assign step_up    = up_btn & ~down_btn;
  assign step_dn    = down_btn & ~up_btn;
  assign capture    = (state == ST_IDLE) && edit_btn;
  assign field_step = (state == ST_EDIT) && !edit_btn && !next_btn;

  // Day limit is taken from the *next* month/year so a month or year step
  // re-clamps the day in the same update.
  date_month_len u_month_len (
    .month   (mon_nx),
    .year_lo (year_nx[1:0]),
    .day_max (mon_max)
  );

  always_comb begin
    state_nx = state;
    fld_nx   = fld;
    mon_nx   = mon;
    year_nx  = year;
    date_nx  = date_in;
    ow_nx    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (edit_btn) begin
          mon_nx   = (cap_mon == 4'd0 || cap_mon > 4'd12) ? 4'd1 : cap_mon;
          year_nx  = date_cur[YEAR_W-1:0];
          fld_nx   = FLD_DAY;
          state_nx = ST_EDIT;
        end
      end
      ST_EDIT: begin
        if (edit_btn) begin
          date_nx  = {day, mon, year};
          ow_nx    = 1'b1;
          state_nx = ST_COMMIT;
        end else if (next_btn) begin
          case (fld)
            FLD_DAY: fld_nx = FLD_MON;
            FLD_MON: fld_nx = FLD_YEAR;
            default: fld_nx = FLD_DAY;
          endcase
        end else if (fld == FLD_MON) begin
          if (step_up)      mon_nx = (mon >= 4'd12) ? 4'd1 : mon + 4'd1;
          else if (step_dn) mon_nx = (mon <= 4'd1) ? 4'd12 : mon - 4'd1;
        end else if (fld == FLD_YEAR) begin
          if (step_up)      year_nx = year + YEAR_W'(1);
          else if (step_dn) year_nx = year - YEAR_W'(1);
        end
      end
      ST_COMMIT: state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    day_nx = day;
    if (capture) begin
      if (cap_day == 5'd0)        day_nx = 5'd1;
      else if (cap_day > mon_max) day_nx = mon_max;
      else                        day_nx = cap_day;
    end else if (field_step) begin
      if (fld == FLD_DAY) begin
        if (step_up)      day_nx = (day >= mon_max) ? 5'd1 : day + 5'd1;
        else if (step_dn) day_nx = (day <= 5'd1) ? mon_max : day - 5'd1;
      end else if (day > mon_max) begin
        day_nx = mon_max;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      fld     <= FLD_DAY;
      day     <= RST_DAY;
      mon     <= RST_MON;
      year    <= '0;
      date_in <= {RST_DAY_MON, {YEAR_W{1'b0}}};
      date_ow <= 1'b0;
    end else begin
      state   <= state_nx;
      fld     <= fld_nx;
      day     <= day_nx;
      mon     <= mon_nx;
      year    <= year_nx;
      date_in <= date_nx;
      date_ow <= ow_nx;
    end
  end

  assign editing   = (state != ST_IDLE);
  assign field_sel = fld;

endmodule
